// File: rtl/wave_pkg.sv
// Shared definitions for the wave summer output path: sample width and DAC
// transmitter state encoding.
package wave_pkg;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned BIT_CNT_W = $clog2(SAMPLE_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/dac_sclk_div.sv
// SCLK generator: divides clk by CLK_DIV per half-period and strikes on each
// rise/fall toggle. Held cleared (sclk low) whenever not enabled.
module dac_sclk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;

    assign tick_c = en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_c = tick_c && !sclk;
    assign fall_c = tick_c && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick_c) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wave_dac_tx.sv
// Serial DAC transmitter: one-entry holding register feeding a 16-bit MSB-first
// shifter on a CPOL=0/CPHA=0 3-wire link, with an enforced cs_n high gap.
module wave_dac_tx
    import wave_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 4,
    parameter bit          OFFSET_BIN = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                dac_sclk,
    output logic                dac_din,
    output logic                dac_cs_n,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [SAMPLE_W-1:0] LOAD_MASK = {OFFSET_BIN, {(SAMPLE_W - 1){1'b0}}};

    tx_state_e              state, state_next;
    logic [SAMPLE_W-1:0]    hold_q, hold_next;
    logic [SAMPLE_W-1:0]    shifter_q, shifter_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_next;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_next;
    logic [SAMPLE_W-1:0]    load_word_c;
    logic                   ready_next, cs_n_next, din_next, done_next;
    logic                   accept_c, load_c, last_fall_c, gap_end_c;
    logic                   rise_c, fall_c;

    dac_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_div (
        .clk   (clk),
        .rst   (rst),
        .en    (state == SHIFT),
        .sclk  (dac_sclk),
        .rise_c(rise_c),
        .fall_c(fall_c)
    );

    assign accept_c    = sample_valid && sample_ready;
    assign load_c      = (state == IDLE) && !sample_ready;
    assign last_fall_c = (state == SHIFT) && fall_c && (bit_cnt_q == BIT_CNT_W'(SAMPLE_W - 1));
    assign gap_end_c   = (state == GAP) && (gap_cnt_q == GAP_W'(CS_GAP - 1));
    assign load_word_c = hold_q ^ LOAD_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_c)      state_next = SHIFT;
            SHIFT:   if (last_fall_c) state_next = GAP;
            GAP:     if (gap_end_c)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath
    always_comb begin
        hold_next    = hold_q;
        ready_next   = sample_ready;
        shifter_next = shifter_q;
        bit_cnt_next = bit_cnt_q;
        gap_cnt_next = '0;
        cs_n_next    = dac_cs_n;
        din_next     = dac_din;
        done_next    = 1'b0;

        if (accept_c) begin
            hold_next  = sample_in;
            ready_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (load_c) begin
                    shifter_next = load_word_c;
                    bit_cnt_next = '0;
                    ready_next   = 1'b1;
                    cs_n_next    = 1'b0;
                    din_next     = load_word_c[SAMPLE_W-1];
                end
            end
            SHIFT: begin
                if (fall_c) begin
                    if (last_fall_c) begin
                        cs_n_next = 1'b1;
                        din_next  = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        shifter_next = {shifter_q[SAMPLE_W-2:0], shifter_q[SAMPLE_W-1]};
                        bit_cnt_next = bit_cnt_q + 1'b1;
                        din_next     = shifter_q[SAMPLE_W-2];
                    end
                end else if (rise_c) begin
                    // DAC captures on this edge; keep the bit steady
                    din_next = dac_din;
                end
            end
            GAP: begin
                gap_cnt_next = gap_end_c ? '0 : gap_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            sample_ready <= 1'b1;
            shifter_q    <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dac_cs_n     <= 1'b1;
            dac_din      <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            hold_q       <= hold_next;
            sample_ready <= ready_next;
            shifter_q    <= shifter_next;
            bit_cnt_q    <= bit_cnt_next;
            gap_cnt_q    <= gap_cnt_next;
            dac_cs_n     <= cs_n_next;
            dac_din      <= din_next;
            frame_done   <= done_next;
            busy         <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_wave_dac_tx.sv
// Bench for wave_dac_tx: three instances (defaults, CLK_DIV=1/CS_GAP=1,
// OFFSET_BIN=1) observed by a link-level frame decoder.
module tb_wave_dac_tx;

    typedef struct {
        logic [15:0] word;
        int          low;
        int          rises;
        int          min_per;
        int          max_per;
        bit          done_at_rise;
        int          gap_before;
        int          fall_cyc;
    } frame_t;

    logic             clk = 1'b0;
    logic [2:0]       rst;
    logic [2:0]       valid;
    logic [2:0][15:0] sin;
    logic [2:0]       ready, sclk, din, cs_n, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    frame_t     fq[3][$];
    frame_t     cur[3];
    int         high_cnt[3];
    int         last_rise[3];
    int         rise_now[3];
    int         done_cnt[3];
    int         din_viol[3];
    logic [2:0] p_sclk = '0;
    logic [2:0] p_cs   = '1;
    logic [2:0] p_din  = '0;

    always #5 clk = ~clk;

    wave_dac_tx #(.CLK_DIV(2), .CS_GAP(4), .OFFSET_BIN(1'b0)) u_def (
        .clk(clk), .rst(rst[0]), .sample_in(sin[0]), .sample_valid(valid[0]),
        .sample_ready(ready[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
        .dac_cs_n(cs_n[0]), .busy(busy[0]), .frame_done(done[0]));

    wave_dac_tx #(.CLK_DIV(1), .CS_GAP(1), .OFFSET_BIN(1'b0)) u_fast (
        .clk(clk), .rst(rst[1]), .sample_in(sin[1]), .sample_valid(valid[1]),
        .sample_ready(ready[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
        .dac_cs_n(cs_n[1]), .busy(busy[1]), .frame_done(done[1]));

    wave_dac_tx #(.CLK_DIV(2), .CS_GAP(4), .OFFSET_BIN(1'b1)) u_ofs (
        .clk(clk), .rst(rst[2]), .sample_in(sin[2]), .sample_valid(valid[2]),
        .sample_ready(ready[2]), .dac_sclk(sclk[2]), .dac_din(din[2]),
        .dac_cs_n(cs_n[2]), .busy(busy[2]), .frame_done(done[2]));

    // Link decoder: rebuilds each frame as the DAC would see it
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) done_cnt[i]++;
            if (p_cs[i] === 1'b1 && cs_n[i] === 1'b0) begin
                cur[i].word         = '0;
                cur[i].low          = 1;
                cur[i].rises        = 0;
                cur[i].min_per      = 1000000;
                cur[i].max_per      = 0;
                cur[i].done_at_rise = 1'b0;
                cur[i].gap_before   = high_cnt[i];
                cur[i].fall_cyc     = cyc;
                rise_now[i]         = 0;
            end else if (cs_n[i] === 1'b0) begin
                cur[i].low++;
                if (p_sclk[i] === 1'b0 && sclk[i] === 1'b1) begin
                    cur[i].word = {cur[i].word[14:0], din[i]};
                    cur[i].rises++;
                    if (cur[i].rises > 1) begin
                        if (cyc - last_rise[i] < cur[i].min_per) cur[i].min_per = cyc - last_rise[i];
                        if (cyc - last_rise[i] > cur[i].max_per) cur[i].max_per = cyc - last_rise[i];
                    end
                    last_rise[i] = cyc;
                    rise_now[i]  = cur[i].rises;
                end
                if (din[i] !== p_din[i] && sclk[i] === 1'b1) din_viol[i]++;
            end
            if (p_cs[i] === 1'b0 && cs_n[i] === 1'b1) begin
                cur[i].done_at_rise = (done[i] === 1'b1);
                fq[i].push_back(cur[i]);
                high_cnt[i] = 1;
            end else if (cs_n[i] === 1'b1) begin
                high_cnt[i]++;
            end
        end
        p_sclk = sclk;
        p_cs   = cs_n;
        p_din  = din;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present v on instance i and hold it until a transfer edge; acc_cyc is
    // the cycle in which valid && ready held.
    task automatic send(input int i, input logic [15:0] v, output int acc_cyc, output int waited);
        sin[i]   = v;
        valid[i] = 1'b1;
        waited   = 0;
        acc_cyc  = -1;
        for (int k = 0; k < 2000; k++) begin
            if (ready[i] === 1'b1) begin
                tick();
                acc_cyc = cyc - 1;
                return;
            end
            waited++;
            tick();
        end
        total++;
        bad++;
        $display("FAIL accept_timeout inst=%0d got=no_accept want=accept", i);
    endtask

    task automatic wait_frames(input int i, input int n, input int budget);
        int k = 0;
        while (fq[i].size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        total++;
        if (fq[i].size() < n) begin
            bad++;
            $display("FAIL frame_timeout inst=%0d got=%0d want=%0d", i, fq[i].size(), n);
        end
    endtask

    task automatic test_reset();
        rst   = '1;
        valid = '0;
        sin   = '0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            total += 6;
            if (cs_n[i] !== 1'b1)  begin bad++; $display("FAIL reset_cs_n inst=%0d got=%b want=1", i, cs_n[i]); end
            if (sclk[i] !== 1'b0)  begin bad++; $display("FAIL reset_sclk inst=%0d got=%b want=0", i, sclk[i]); end
            if (din[i] !== 1'b0)   begin bad++; $display("FAIL reset_din inst=%0d got=%b want=0", i, din[i]); end
            if (ready[i] !== 1'b1) begin bad++; $display("FAIL reset_ready inst=%0d got=%b want=1", i, ready[i]); end
            if (busy[i] !== 1'b0)  begin bad++; $display("FAIL reset_busy inst=%0d got=%b want=0", i, busy[i]); end
            if (done[i] !== 1'b0)  begin bad++; $display("FAIL reset_done inst=%0d got=%b want=0", i, done[i]); end
        end
        rst = '0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) fq[i].delete();
    endtask

    task automatic test_single();
        int acc, w, d0;
        frame_t f;
        d0 = done_cnt[0];
        fq[0].delete();
        send(0, 16'hA5C3, acc, w);
        valid[0] = 1'b0;
        wait_frames(0, 1, 300);
        if (fq[0].size() >= 1) begin
            f = fq[0][0];
            total += 6;
            if (f.word !== 16'hA5C3) begin bad++; $display("FAIL single_word got=%h want=a5c3", f.word); end
            if (f.low != 64)         begin bad++; $display("FAIL single_cs_low got=%0d want=64", f.low); end
            if (f.rises != 16)       begin bad++; $display("FAIL single_rises got=%0d want=16", f.rises); end
            if (f.min_per != 4 || f.max_per != 4) begin
                bad++; $display("FAIL single_sclk_period got=%0d..%0d want=4", f.min_per, f.max_per);
            end
            if (!f.done_at_rise)     begin bad++; $display("FAIL single_done_at_cs_rise got=0 want=1"); end
            if (f.fall_cyc - acc != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", f.fall_cyc - acc); end
        end
        repeat (10) tick();
        total += 3;
        if (done_cnt[0] - d0 != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt[0] - d0); end
        if (cs_n[0] !== 1'b1)      begin bad++; $display("FAIL single_cs_idle got=%b want=1", cs_n[0]); end
        if (busy[0] !== 1'b0)      begin bad++; $display("FAIL single_busy_idle got=%b want=0", busy[0]); end
    endtask

    task automatic test_offset();
        logic [15:0] vals[6];
        int acc, w;
        vals[0] = 16'h8000;
        vals[1] = 16'h7FFF;
        for (int k = 2; k < 6; k++) vals[k] = 16'($urandom);
        fq[2].delete();
        for (int k = 0; k < 6; k++) send(2, vals[k], acc, w);
        valid[2] = 1'b0;
        wait_frames(2, 6, 600);
        for (int k = 0; k < 6 && k < fq[2].size(); k++) begin
            total++;
            if (fq[2][k].word !== (vals[k] ^ 16'h8000)) begin
                bad++;
                $display("FAIL offset_word idx=%0d got=%h want=%h", k, fq[2][k].word, vals[k] ^ 16'h8000);
            end
        end
        repeat (10) tick();
    endtask

    // Back-to-back stream on instance i; checks order, spacing and shape
    task automatic stream(input int i, input int div, input int gap, input string tag);
        logic [15:0] vals[6];
        int acc, w, any_wait;
        vals[0] = 16'h0001;
        vals[1] = 16'h0002;
        vals[2] = 16'h0003;
        for (int k = 3; k < 6; k++) vals[k] = 16'($urandom);
        fq[i].delete();
        any_wait = 0;
        for (int k = 0; k < 6; k++) begin
            send(i, vals[k], acc, w);
            if (w > 0) any_wait = 1;
        end
        valid[i] = 1'b0;
        wait_frames(i, 6, 700);
        total++;
        if (any_wait != 1) begin bad++; $display("FAIL %s_ready_drop got=%0d want=1", tag, any_wait); end
        for (int k = 0; k < 6 && k < fq[i].size(); k++) begin
            total += 3;
            if (fq[i][k].word !== vals[k]) begin
                bad++; $display("FAIL %s_word idx=%0d got=%h want=%h", tag, k, fq[i][k].word, vals[k]);
            end
            if (fq[i][k].low != 32 * div || fq[i][k].rises != 16) begin
                bad++; $display("FAIL %s_shape idx=%0d got=low%0d/r%0d want=low%0d/r16", tag, k, fq[i][k].low, fq[i][k].rises, 32 * div);
            end
            if (fq[i][k].min_per != 2 * div || fq[i][k].max_per != 2 * div) begin
                bad++; $display("FAIL %s_sclk_period idx=%0d got=%0d..%0d want=%0d", tag, k, fq[i][k].min_per, fq[i][k].max_per, 2 * div);
            end
            if (k > 0) begin
                total += 2;
                if (fq[i][k].fall_cyc - fq[i][k-1].fall_cyc != 32 * div + gap + 1) begin
                    bad++; $display("FAIL %s_period idx=%0d got=%0d want=%0d", tag, k, fq[i][k].fall_cyc - fq[i][k-1].fall_cyc, 32 * div + gap + 1);
                end
                if (fq[i][k].gap_before != gap + 1) begin
                    bad++; $display("FAIL %s_cs_gap idx=%0d got=%0d want=%0d", tag, k, fq[i][k].gap_before, gap + 1);
                end
            end
        end
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        stream(0, 2, 4, "b2b");
    endtask

    task automatic test_fast_clock();
        stream(1, 1, 1, "fast");
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] x, y;
        int acc, w, k;
        x = 16'($urandom);
        y = 16'($urandom);
        fq[0].delete();
        send(0, x, acc, w);
        send(0, y, acc, w);
        valid[0] = 1'b0;
        k = 0;
        while (!(cs_n[0] === 1'b0 && rise_now[0] == 8) && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        total++;
        if (k >= 300) begin bad++; $display("FAIL midrst_rise8_timeout got=%0d want=8", rise_now[0]); end
        rst[0] = 1'b1;
        tick();
        total += 6;
        if (cs_n[0] !== 1'b1)  begin bad++; $display("FAIL midrst_cs_n got=%b want=1", cs_n[0]); end
        if (sclk[0] !== 1'b0)  begin bad++; $display("FAIL midrst_sclk got=%b want=0", sclk[0]); end
        if (din[0] !== 1'b0)   begin bad++; $display("FAIL midrst_din got=%b want=0", din[0]); end
        if (ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", ready[0]); end
        if (busy[0] !== 1'b0)  begin bad++; $display("FAIL midrst_busy got=%b want=0", busy[0]); end
        if (done[0] !== 1'b0)  begin bad++; $display("FAIL midrst_done got=%b want=0", done[0]); end
        rst[0] = 1'b0;
        @(negedge clk);
        #1;
        fq[0].delete();
        tick();
        send(0, 16'h1234, acc, w);
        valid[0] = 1'b0;
        wait_frames(0, 1, 300);
        repeat (200) tick();
        total++;
        if (fq[0].size() != 1) begin bad++; $display("FAIL midrst_frame_count got=%0d want=1", fq[0].size()); end
        if (fq[0].size() >= 1) begin
            total++;
            if (fq[0][0].word !== 16'h1234 || fq[0][0].rises != 16) begin
                bad++; $display("FAIL midrst_word got=%h/r%0d want=1234/r16", fq[0][0].word, fq[0][0].rises);
            end
        end
    endtask

    task automatic test_valid_while_full();
        logic [15:0] a, b, c, d;
        int acc, w;
        a = 16'($urandom);
        b = 16'($urandom);
        c = 16'($urandom);
        d = c ^ 16'h5A5A;
        fq[0].delete();
        send(0, a, acc, w);
        send(0, b, acc, w);
        valid[0] = 1'b0;
        repeat (3) tick();
        total++;
        if (ready[0] !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready[0]); end
        sin[0]   = c;
        valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        repeat (5) tick();
        send(0, d, acc, w);
        valid[0] = 1'b0;
        total++;
        if (w == 0) begin bad++; $display("FAIL full_wait got=%0d want=>0", w); end
        wait_frames(0, 3, 400);
        repeat (150) tick();
        total++;
        if (fq[0].size() != 3) begin bad++; $display("FAIL full_frame_count got=%0d want=3", fq[0].size()); end
        if (fq[0].size() >= 3) begin
            total += 3;
            if (fq[0][0].word !== a) begin bad++; $display("FAIL full_word0 got=%h want=%h", fq[0][0].word, a); end
            if (fq[0][1].word !== b) begin bad++; $display("FAIL full_word1 got=%h want=%h", fq[0][1].word, b); end
            if (fq[0][2].word !== d) begin bad++; $display("FAIL full_word2 got=%h want=%h", fq[0][2].word, d); end
        end
    endtask

    task automatic test_din_stability();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (din_viol[i] != 0) begin
                bad++; $display("FAIL din_stable inst=%0d got=%0d want=0", i, din_viol[i]);
            end
        end
    endtask

    initial begin
        rst   = '1;
        valid = '0;
        sin   = '0;
        test_reset();
        test_single();
        test_offset();
        test_back_to_back();
        test_fast_clock();
        test_reset_mid_frame();
        test_valid_while_full();
        test_din_stability();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_dac_tx.md
# wave_dac_tx

Serial DAC transmitter downstream of the four-channel wave summer. Accepts the 16-bit summed sample over a valid/ready handshake and shifts it out MSB-first on a 3-wire SPI-style link (SCLK/DIN/CS_n, CPOL=0, CPHA=0) to an external 16-bit DAC. A one-entry holding register lets the next sample be accepted while the current frame shifts.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period; legal range ≥1.
- CS_GAP, 4: minimum clk cycles cs_n stays high between frames; legal range ≥1.
- OFFSET_BIN, 0: 1 = invert the sample MSB on load (two's complement to offset binary).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  16  sample from the wave summer.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding register can accept a sample.
- dac_sclk  out  1  serial clock, idles low.
- dac_din  out  1  serial data, MSB first.
- dac_cs_n  out  1  frame select, active low.
- busy  out  1  high when the state is not IDLE.
- frame_done  out  1  one-cycle pulse on the cycle cs_n returns high.

## Operation
- Handshake: a transfer occurs on a rising edge with sample_valid && sample_ready. sample_ready = !hold_full. A sample held in the register is never overwritten. Upstream holds sample_in/valid until accepted.
- States are IDLE, SHIFT and GAP.
- IDLE: if hold_full, load the shifter from hold, with the MSB inverted when OFFSET_BIN=1. Clear hold_full, drive cs_n=0, drive din=shifter[15] and go to SHIFT. The load takes one cycle. An accept in the same cycle as the load is impossible because sample_ready is low.
- SHIFT: div_cnt counts 0..CLK_DIV-1. At the terminal count sclk toggles.
  - On a 0→1 toggle, din is held; the DAC samples on this edge.
  - On a 1→0 toggle, bit_cnt increments and din presents the next bit.
  - On the 16th falling toggle, drive cs_n=1 and din=0, pulse frame_done, and go to GAP.
- GAP: count CS_GAP cycles with cs_n high, then go to IDLE.
- A new sample may be accepted into hold during SHIFT and GAP. Samples are never dropped. Throughput is limited by back-pressure.

## Timing
- Reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, sample_ready=1, busy=0, frame_done=0. Hold, shifter and counters are cleared.
- Reset mid-frame: outputs take their reset values on the next edge and the held sample is discarded. No partial frame resumes.
- Latency, accept to cs_n low: 2 cycles from IDLE with hold empty. The first edge registers hold; the next edge loads the shifter.
- cs_n is low for 32·CLK_DIV cycles. The first SCLK rise occurs CLK_DIV cycles after cs_n falls. SCLK is low when cs_n rises.
- Minimum frame period = 32·CLK_DIV + CS_GAP + 1 cycles; 69 cycles at the defaults.
- din changes only while sclk is low, or on a cs_n transition. It is stable for CLK_DIV cycles around each SCLK rise.
- Back-to-back operation: with hold already full at the end of GAP, the next cs_n fall occurs exactly 1 cycle after IDLE is entered.

## Structure
- The shared package wave_pkg holds SAMPLE_W=16 and the state enum (IDLE, SHIFT, GAP).
- The natural sub-module is dac_sclk_div: the CLK_DIV counter producing rise/fall toggle strikes. It is enabled only in SHIFT and cleared otherwise.
- The FSM, hold register and shifter live in wave_dac_tx. Target size is about 150–250 lines of RTL.

## Test plan
- Single sample 0xA5C3 at the defaults:
  - cs_n is low for 64 cycles with 16 SCLK rises.
  - DIN sampled on the rises reads 1010_0101_1100_0011.
  - frame_done pulses once.
  - cs_n stays high for ≥4 cycles.
- OFFSET_BIN=1, sample 0x8000: the shifted word is 0x0000. Sample 0x7FFF: the shifted word is 0xFFFF.
- Continuous valid with samples 0x0001, 0x0002, 0x0003:
  - sample_ready drops while hold is full.
  - Frames start 69 cycles apart.
  - All three words appear in order with none lost.
- CLK_DIV=1, CS_GAP=1: SCLK period is 2 cycles, cs_n is low for 32 cycles, and the frame period is 34 cycles.
- rst asserted on the 8th SCLK rise, then a new sample 0x1234:
  - Outputs take their reset values on the next edge.
  - The held sample is discarded.
  - The next frame carries only 0x1234.
- Valid pulsed while hold is full, with the upstream later holding valid: no transfer occurs until ready rises. The accepted value equals the one presented at acceptance.
